// File: rtl/nibble_sched_pkg.sv
// Shared types and constants for the nibble transmit scheduler.
package nibble_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ASK   = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int             CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/nibble_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest index at or after ptr (mod NREQ) with req set.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win_id,
  output logic            any_req
);

  int idx;

  // Scan from the far end back toward ptr so the closest candidate is assigned last.
  always_comb begin
    win_id  = '0;
    any_req = |req;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) win_id = IW'(idx);
    end
  end

endmodule

// File: rtl/nibble_tx_scheduler.sv
// Round-robin scheduler feeding one nibble serializer from NREQ sources.
// Optional per-source grant counters are enabled with NIBBLE_SCHED_STATS_EN.
module nibble_tx_scheduler
  import nibble_sched_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int SETTLE = 1,
  parameter  int DW     = 4,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ask_for_data,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [DW-1:0]     tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [IW-1:0]     grant_id,
  output logic              sched_busy
`ifdef NIBBLE_SCHED_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic [IW-1:0]   ptr, win_id;
  logic            any_req;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win_id  (win_id),
    .any_req (any_req)
  );

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = ASK;
      ASK:                    state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = LOAD;
      LOAD:    if (tx_busy)   state_nxt = DRAIN;
      DRAIN:   if (!tx_busy)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    ask_for_data = '0;
    if (state == ASK) ask_for_data[grant_id] = 1'b1;
    tx_start   = (state == LOAD);
    sched_busy = (state != IDLE);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_id <= win_id;
        ptr      <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (state == ASK)
        cnt <= 4'(SETTLE - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0)
        tx_data <= data_in[grant_id*DW +: DW];
    end
  end

`ifdef NIBBLE_SCHED_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CNT_W-1:0] c;
    always_ff @(posedge sclk) begin
      if (rst)
        c <= '0;
      else if (state == ASK && grant_id == IW'(i) && c != CNT_MAX)
        c <= c + 1'b1;
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = c;
  end
`endif

endmodule

// File: tb/tb_nibble_tx_scheduler.sv
// Directed bench for nibble_tx_scheduler (NREQ=4, SETTLE=1, DW=4).
module tb_nibble_tx_scheduler;

  logic        sclk = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  req  = '0;
  logic [3:0]  ask_for_data;
  logic [15:0] data_in = '0;
  logic [3:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        sched_busy;
`ifdef NIBBLE_SCHED_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  nibble_tx_scheduler #(.NREQ(4), .SETTLE(1), .DW(4)) dut (
    .sclk         (sclk),
    .rst          (rst),
    .req          (req),
    .ask_for_data (ask_for_data),
    .data_in      (data_in),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .sched_busy   (sched_busy)
`ifdef NIBBLE_SCHED_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] data;
    bit          early;
    int          exp_id;
    logic [3:0]  exp_d;
  } vec_t;

  vec_t vt[7];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transfer starting from IDLE; serializer busy for 4 cycles unless early.
  task automatic xfer(input logic [3:0] r, input logic [15:0] d, input bit hold,
                      input bit early, input int exp_id, input logic [3:0] exp_d);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << exp_id;
    req = r;
    data_in = d;
    tick();
    check("ask_pulse", ask_for_data, oh);
    check("grant_id", grant_id, exp_id);
    check("busy_ask", sched_busy, 1);
    if (!hold) req = '0;
    if (early) tx_busy = 1'b1;
    tick();
    check("ask_clear", ask_for_data, 0);
    check("start_wait", tx_start, 0);
    tick();
    check("tx_start", tx_start, 1);
    check("tx_data", tx_data, exp_d);
    tx_busy = 1'b1;
    tick();
    check("start_drop", tx_start, 0);
    check("busy_drain", sched_busy, 1);
    if (!early) repeat (3) tick();
    tx_busy = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (sched_busy && n < 8);
    check("idle_return", sched_busy, 0);
    check("tx_data_hold", tx_data, exp_d);
    if (!hold) begin
      tick();
      check("no_reask", ask_for_data, 0);
      check("stay_idle", sched_busy, 0);
    end
  endtask

  initial begin
    vt[0] = '{4'b0100, 16'h0A00, 1'b0, 2, 4'hA};
    vt[1] = '{4'b1001, 16'h5003, 1'b0, 3, 4'h5};
    vt[2] = '{4'b1001, 16'h5003, 1'b0, 0, 4'h3};
    vt[3] = '{4'b0011, 16'h00C7, 1'b1, 1, 4'hC};
    vt[4] = '{4'b0001, 16'h000E, 1'b0, 0, 4'hE};
    vt[5] = '{4'b1110, 16'h9870, 1'b0, 1, 4'h7};
    vt[6] = '{4'b1000, 16'hF000, 1'b0, 3, 4'hF};

    rst = 1'b1;
    repeat (2) tick();
    check("rst_ask", ask_for_data, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", sched_busy, 0);
    rst = 1'b0;
    tick();

    // Reset while held in LOAD; ptr would be 3 after granting source 2.
    req = 4'b0100;
    data_in = 16'h0A00;
    tick();
    req = '0;
    tick();
    tick();
    check("mid_load_start", tx_start, 1);
    tick();
    check("mid_load_hold", tx_start, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_ask", ask_for_data, 0);
    check("rst2_start", tx_start, 0);
    check("rst2_data", tx_data, 0);
    check("rst2_gid", grant_id, 0);
    check("rst2_busy", sched_busy, 0);
    xfer(4'b1111, 16'h4321, 1'b0, 1'b0, 0, 4'h1);

    for (int i = 0; i < 7; i++)
      xfer(vt[i].req, vt[i].data, 1'b0, vt[i].early, vt[i].exp_id, vt[i].exp_d);

    // All sources held: one pulse each per round, then wrap back to 0.
    xfer(4'b1111, 16'h4321, 1'b1, 1'b0, 0, 4'h1);
    xfer(4'b1111, 16'h4321, 1'b1, 1'b0, 1, 4'h2);
    xfer(4'b1111, 16'h4321, 1'b1, 1'b0, 2, 4'h3);
    xfer(4'b1111, 16'h4321, 1'b1, 1'b0, 3, 4'h4);
    xfer(4'b1111, 16'h4321, 1'b1, 1'b0, 0, 4'h1);
    req = '0;
    tick();
    check("held_no_extra", ask_for_data, 0);

`ifdef NIBBLE_SCHED_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rst", grant_cnt, 0);
    for (int i = 0; i < 300; i++)
      xfer(4'b0010, 16'h00B0, 1'b0, 1'b0, 1, 4'hB);
    check("cnt_sat", grant_cnt[15:8], 8'd255);
    check("cnt_others", {grant_cnt[31:16], grant_cnt[7:0]}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
